// File: rtl/s9234_test_2_if.sv
// Pin bundle for s9234_test_2: 36 stimulus pins and 39 observation pins.
// The slave modport is the DUT's view; the master modport is the driver's view.
interface s9234_test_2_if;
    // operands A and B, data byte D
    logic g89, g94, g98, g102, g107;
    logic g301, g306, g310, g314, g319;
    logic g557, g558, g559, g560, g561, g562, g563, g564;
    // register enables
    logic g705, g639, g567, g45, g42, g39, g702;
    // control flags CTL[10:0]
    logic g32, g38, g46, g36, g47, g40, g37, g41, g22, g44, g23;
    // MISR[15:0]
    logic g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137;
    logic g5468, g5469, g5692, g6282, g6284, g6360, g6362, g6364;
    // ACC[4:0], parity, DREG[7:0], CNT[3:0], folded CTL[4:0]
    logic g6366, g6368, g6370, g6372, g6374;
    logic g6728;
    logic g1290, g4121, g4108, g4106, g4103, g1293, g4099, g4102;
    logic g4109, g4100, g4112, g4105;
    logic g4101, g4110, g4104, g4107, g4098;

    modport slave (
        input  g89, g94, g98, g102, g107,
        input  g301, g306, g310, g314, g319,
        input  g557, g558, g559, g560, g561, g562, g563, g564,
        input  g705, g639, g567, g45, g42, g39, g702,
        input  g32, g38, g46, g36, g47, g40, g37, g41, g22, g44, g23,
        output g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137,
        output g5468, g5469, g5692, g6282, g6284, g6360, g6362, g6364,
        output g6366, g6368, g6370, g6372, g6374,
        output g6728,
        output g1290, g4121, g4108, g4106, g4103, g1293, g4099, g4102,
        output g4109, g4100, g4112, g4105,
        output g4101, g4110, g4104, g4107, g4098
    );

    modport master (
        output g89, g94, g98, g102, g107,
        output g301, g306, g310, g314, g319,
        output g557, g558, g559, g560, g561, g562, g563, g564,
        output g705, g639, g567, g45, g42, g39, g702,
        output g32, g38, g46, g36, g47, g40, g37, g41, g22, g44, g23,
        input  g2584, g3222, g3600, g4307, g4321, g4422, g4809, g5137,
        input  g5468, g5469, g5692, g6282, g6284, g6360, g6362, g6364,
        input  g6366, g6368, g6370, g6372, g6374,
        input  g6728,
        input  g1290, g4121, g4108, g4106, g4103, g1293, g4099, g4102,
        input  g4109, g4100, g4112, g4105,
        input  g4101, g4110, g4104, g4107, g4098
    );
endinterface

// File: rtl/s9234_test_2.sv
// s9234_test_2: synthetic sequential test block holding a 5-bit accumulator,
// 8-bit data register with rotate, 4-bit event counter, 11-bit control
// capture and a 16-bit signature register. Outputs decode registered state only.
// Macro S9234_MISR_EN: when defined the signature register is a CRC-style MISR
// (poly 0x1021); when undefined it is a plain capture of {DREG,3'b000,ACC}.
module s9234_test_2 (
    input  logic           CK,
    input  logic           RSTN,
    s9234_test_2_if.slave  bus
);
    logic [4:0]  a_in, b_in;
    logic [7:0]  d_in;
    logic [10:0] ctl_in;

    logic [4:0]  acc_q,  acc_d;
    logic [7:0]  dreg_q, dreg_d;
    logic [3:0]  cnt_q,  cnt_d;
    logic [10:0] ctl_q,  ctl_d;
    logic [15:0] misr_q, misr_d;
    logic [15:0] misr_in;

    assign a_in   = {bus.g89, bus.g94, bus.g98, bus.g102, bus.g107};
    assign b_in   = {bus.g301, bus.g306, bus.g310, bus.g314, bus.g319};
    assign d_in   = {bus.g557, bus.g558, bus.g559, bus.g560,
                     bus.g561, bus.g562, bus.g563, bus.g564};
    assign ctl_in = {bus.g32, bus.g38, bus.g46, bus.g36, bus.g47, bus.g40,
                     bus.g37, bus.g41, bus.g22, bus.g44, bus.g23};

    // Word folded into the signature: current DREG and ACC, padded to 16 bits.
    assign misr_in = {dreg_q, 3'b000, acc_q};

    // Next-state logic for every register; holds are the default.
    always_comb begin
        acc_d  = acc_q;
        dreg_d = dreg_q;
        cnt_d  = cnt_q;
        ctl_d  = ctl_in;
        misr_d = misr_q;

        if (bus.g705)
            acc_d = bus.g639 ? (a_in ^ b_in) : (a_in + b_in);

        if (bus.g567)
            dreg_d = d_in;
        else if (bus.g45)
            dreg_d = {dreg_q[6:0], dreg_q[7]};

        if (bus.g39)
            cnt_d = 4'd0;
        else if (bus.g42)
            cnt_d = cnt_q + 4'd1;

        if (bus.g702) begin
`ifdef S9234_MISR_EN
            misr_d = {misr_q[14:0], 1'b0}
                   ^ (misr_q[15] ? 16'h1021 : 16'h0000)
                   ^ misr_in;
`else
            misr_d = misr_in;
`endif
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            acc_q  <= '0;
            dreg_q <= '0;
            cnt_q  <= '0;
            ctl_q  <= '0;
            misr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dreg_q <= dreg_d;
            cnt_q  <= cnt_d;
            ctl_q  <= ctl_d;
            misr_q <= misr_d;
        end
    end

    // Output decode, purely from registered state.
    assign {bus.g2584, bus.g3222, bus.g3600, bus.g4307,
            bus.g4321, bus.g4422, bus.g4809, bus.g5137,
            bus.g5468, bus.g5469, bus.g5692, bus.g6282,
            bus.g6284, bus.g6360, bus.g6362, bus.g6364} = misr_q;
    assign {bus.g6366, bus.g6368, bus.g6370, bus.g6372, bus.g6374} = acc_q;
    assign bus.g6728 = (^dreg_q) ^ ctl_q[10];
    assign {bus.g1290, bus.g4121, bus.g4108, bus.g4106,
            bus.g4103, bus.g1293, bus.g4099, bus.g4102} = dreg_q;
    assign {bus.g4109, bus.g4100, bus.g4112, bus.g4105} = cnt_q;
    assign {bus.g4101, bus.g4110, bus.g4104, bus.g4107, bus.g4098} =
           ctl_q[4:0] ^ ctl_q[9:5];
endmodule

// File: tb/tb_s9234_test_2.sv
// Directed-vector bench for s9234_test_2; expected values are hand-computed.
module tb_s9234_test_2;
    logic CK;
    logic RSTN;
    int   n_vec;
    int   n_err;

    s9234_test_2_if bus ();

    s9234_test_2 dut (
        .CK   (CK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    logic [15:0] misr_o;
    logic [4:0]  acc_o;
    logic [7:0]  dreg_o;
    logic [3:0]  cnt_o;
    logic [4:0]  fold_o;
    logic        par_o;
    logic [38:0] all_o;

    assign misr_o = {bus.g2584, bus.g3222, bus.g3600, bus.g4307,
                     bus.g4321, bus.g4422, bus.g4809, bus.g5137,
                     bus.g5468, bus.g5469, bus.g5692, bus.g6282,
                     bus.g6284, bus.g6360, bus.g6362, bus.g6364};
    assign acc_o  = {bus.g6366, bus.g6368, bus.g6370, bus.g6372, bus.g6374};
    assign dreg_o = {bus.g1290, bus.g4121, bus.g4108, bus.g4106,
                     bus.g4103, bus.g1293, bus.g4099, bus.g4102};
    assign cnt_o  = {bus.g4109, bus.g4100, bus.g4112, bus.g4105};
    assign fold_o = {bus.g4101, bus.g4110, bus.g4104, bus.g4107, bus.g4098};
    assign par_o  = bus.g6728;
    assign all_o  = {misr_o, acc_o, par_o, dreg_o, cnt_o, fold_o};

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic [4:0] v);
        {bus.g89, bus.g94, bus.g98, bus.g102, bus.g107} = v;
    endtask
    task automatic set_b(input logic [4:0] v);
        {bus.g301, bus.g306, bus.g310, bus.g314, bus.g319} = v;
    endtask
    task automatic set_d(input logic [7:0] v);
        {bus.g557, bus.g558, bus.g559, bus.g560,
         bus.g561, bus.g562, bus.g563, bus.g564} = v;
    endtask
    task automatic set_ctl(input logic [10:0] v);
        {bus.g32, bus.g38, bus.g46, bus.g36, bus.g47, bus.g40,
         bus.g37, bus.g41, bus.g22, bus.g44, bus.g23} = v;
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RSTN  = 1'b1;
        set_a(5'd19); set_b(5'd7); set_d(8'hA5); set_ctl(11'h3C3);
        bus.g705 = 1'b1; bus.g639 = 1'b0; bus.g567 = 1'b1; bus.g45 = 1'b1;
        bus.g42  = 1'b1; bus.g39  = 1'b0; bus.g702 = 1'b1;

        // Asynchronous reset before any clock edge.
        #1 RSTN = 1'b0;
        #1 check("reset_no_edge", all_o, 39'h0);
        @(negedge CK);
        check("reset_held_edge", all_o, 39'h0);

        // Static vector.
        set_a(5'd27); set_b(5'd0); set_d(8'hD7); set_ctl(11'b101_0010_1010);
        bus.g705 = 1'b1; bus.g639 = 1'b0; bus.g567 = 1'b1;
        bus.g45 = 1'b0; bus.g42 = 1'b0; bus.g39 = 1'b0; bus.g702 = 1'b1;
        RSTN = 1'b1;
        tick();
        check("e1_acc",  {34'h0, acc_o},  {34'h0, 5'h1B});
        check("e1_dreg", {31'h0, dreg_o}, {31'h0, 8'hD7});
        check("e1_cnt",  {35'h0, cnt_o},  39'h0);
        check("e1_misr", {23'h0, misr_o}, 39'h0);
        check("e1_fold", {34'h0, fold_o}, {34'h0, 5'b00011});
        check("e1_par",  {38'h0, par_o},  39'h1);
        tick();
        check("e2_misr", {23'h0, misr_o}, {23'h0, 16'hD71B});
        tick();
`ifdef S9234_MISR_EN
        check("e3_misr", {23'h0, misr_o}, {23'h0, 16'h690C});
`else
        check("e3_misr", {23'h0, misr_o}, {23'h0, 16'hD71B});
`endif
        // MISR hold when step disabled.
        bus.g702 = 1'b0;
        set_d(8'h11);
        tick(); tick();
`ifdef S9234_MISR_EN
        check("misr_hold", {23'h0, misr_o}, {23'h0, 16'h690C});
`else
        check("misr_hold", {23'h0, misr_o}, {23'h0, 16'hD71B});
`endif

        // Reset mid-cycle clears immediately.
        #2 RSTN = 1'b0;
        #1 check("reset_mid_cycle", all_o, 39'h0);
        @(negedge CK);
        RSTN = 1'b1;

        // Accumulator add wrap, xor, hold.
        bus.g567 = 1'b0;
        set_a(5'd31); set_b(5'd1); bus.g705 = 1'b1; bus.g639 = 1'b0;
        tick();
        check("acc_add_wrap", {34'h0, acc_o}, 39'h0);
        bus.g639 = 1'b1;
        tick();
        check("acc_xor", {34'h0, acc_o}, {34'h0, 5'd30});
        bus.g705 = 1'b0; set_a(5'd5);
        tick();
        check("acc_hold", {34'h0, acc_o}, {34'h0, 5'd30});

        // Data register load, rotate, load priority.
        set_d(8'h81); bus.g567 = 1'b1; bus.g45 = 1'b0;
        tick();
        check("dreg_load", {31'h0, dreg_o}, {31'h0, 8'h81});
        bus.g567 = 1'b0; bus.g45 = 1'b1;
        tick();
        check("dreg_rot1", {31'h0, dreg_o}, {31'h0, 8'h03});
        tick();
        check("dreg_rot2", {31'h0, dreg_o}, {31'h0, 8'h06});
        set_d(8'h5A); bus.g567 = 1'b1;
        tick();
        check("dreg_load_prio", {31'h0, dreg_o}, {31'h0, 8'h5A});
        bus.g567 = 1'b0; bus.g45 = 1'b0;

        // Counter: partial count, full wrap, clear priority.
        bus.g42 = 1'b1; bus.g39 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("cnt_5", {35'h0, cnt_o}, {35'h0, 4'd5});
        for (int i = 0; i < 11; i++) tick();
        check("cnt_wrap", {35'h0, cnt_o}, 39'h0);
        for (int i = 0; i < 3; i++) tick();
        check("cnt_3", {35'h0, cnt_o}, {35'h0, 4'd3});
        bus.g39 = 1'b1;
        tick();
        check("cnt_clear_prio", {35'h0, cnt_o}, 39'h0);
        bus.g39 = 1'b0; bus.g42 = 1'b0;
        tick();
        check("cnt_hold", {35'h0, cnt_o}, 39'h0);

        // Control capture and parity with DREG=0x5A (even parity).
        set_ctl(11'h01F);
        tick();
        check("ctl_fold_lo", {34'h0, fold_o}, {34'h0, 5'b11111});
        check("par_ctl0", {38'h0, par_o}, 39'h0);
        set_ctl(11'h7FF);
        tick();
        check("ctl_fold_all", {34'h0, fold_o}, 39'h0);
        check("par_ctl1", {38'h0, par_o}, 39'h1);
        set_ctl(11'h3E0);
        tick();
        check("ctl_fold_hi", {34'h0, fold_o}, {34'h0, 5'b11111});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
